// File: rtl/dm_copy_engine.sv
// dm_copy_engine: word-copy initiator that masters the data-memory port.
// Each word takes one READ cycle (combinational memory read, captured on the
// edge) followed by one WRITE cycle (memory commits on the edge).
// Optional feature macro: DM_COPY_CHECKSUM_EN enables a running sum of the
// copied words on the checksum output; without it checksum is tied to 0.
`timescale 1ns/1ps

module dm_copy_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  src;
    logic [ADDR_W-1:0]  dst;
    logic [LEN_W-1:0]   remaining;
    logic [DATA_W-1:0]  buffer;

    // Copy sequencer: walks READ/WRITE pairs in ascending address order and
    // produces the registered busy/done/aborted status.
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            buffer    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    // start wins over a simultaneous abort here.
                    if (start) begin
                        src       <= src_addr;
                        dst       <= dst_addr;
                        remaining <= len;
                        if (len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else begin
                        buffer <= mem_rdata;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    // The write of this cycle commits even when abort is seen.
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else begin
                        src       <= src + ADDR_W'(1);
                        dst       <= dst + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory-port decode from registered state, so strobes cannot glitch and
    // mem_read/mem_write are mutually exclusive by construction.
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            READ: begin
                mem_read = 1'b1;
                mem_addr = src;
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = dst;
                mem_wdata = buffer;
            end
            default: begin
            end
        endcase
    end

`ifdef DM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    // Running sum of every word written; cleared on start accept and held
    // after done/aborted until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (state == IDLE && start) begin
            sum <= '0;
        end else if (state == WRITE) begin
            sum <= sum + buffer;
        end
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dm_copy_engine.sv
// Self-checking bench for dm_copy_engine. Stimulus pushes the expected memory
// transactions and completion pulses into a queue; a negedge monitor pops and
// compares them (kind, cycle, address, data/checksum) whenever the DUT
// strobes mem_read, mem_write, done or aborted. The memory model is 256 words
// indexed by the low address byte, so address wrap is observable.
`timescale 1ns/1ps

module tb_dm_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] checksum;

    typedef enum int {EV_READ = 0, EV_WRITE = 1, EV_DONE = 2, EV_ABORT = 3} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    logic [31:0] mem [256];
    logic [31:0] shadow [256];
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [31:0] poke_data;

    dm_copy_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: combinational read, clocked write; bench preloads via poke.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (poke_en)        mem[poke_addr]     <= poke_data;
        else if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_checksum(input logic [31:0] s);
`ifdef DM_COPY_CHECKSUM_EN
        return s;
`else
        return 32'd0;
`endif
    endfunction

    task automatic push(input ev_kind_t k, input int c, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_event(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected DUT event kind", 64'(k), 64'hFF);
        end else begin
            e = exp_q.pop_front();
            check("event kind", 64'(k), 64'(e.kind));
            check("event cycle", 64'(cyc), 64'(e.cyc));
            if (k == EV_READ || k == EV_WRITE) check("event addr", 64'(a), 64'(e.addr));
            if (k != EV_READ) check("event data/checksum", 64'(d), 64'(e.data));
        end
    endtask

    // Monitor: scoreboard consumer, sampling on the falling edge.
    always @(negedge clk) begin
        check("busy tracks READ/WRITE", 64'(busy), 64'(mem_read | mem_write));
        check("read/write exclusive", 64'(mem_read & mem_write), 64'd0);
        if (mem_read)  expect_event(EV_READ, mem_addr, 32'd0);
        if (mem_write) expect_event(EV_WRITE, mem_addr, mem_wdata);
        if (done)      expect_event(EV_DONE, 32'd0, checksum);
        if (aborted)   expect_event(EV_ABORT, 32'd0, checksum);
    end

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        shadow[a] = d;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Issues one copy and queues its expected transactions. abort_after>0
    // raises abort during that WRITE (1-based), so only that many words land.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input int abort_after, input logic abort_with_start);
        int          e;
        int          k;
        logic [31:0] ra;
        logic [31:0] wa;
        logic [31:0] v;
        logic [31:0] sum;
        @(negedge clk);
        e   = cyc + 1;
        k   = (abort_after > 0 && abort_after < int'(n)) ? abort_after : int'(n);
        sum = 32'd0;
        for (int i = 0; i < k; i++) begin
            ra = s + 32'(i);
            wa = d + 32'(i);
            v  = shadow[ra[7:0]];
            push(EV_READ, e + 2 * i, ra, 32'd0);
            shadow[wa[7:0]] = v;
            push(EV_WRITE, e + 2 * i + 1, wa, v);
            sum = sum + v;
        end
        push((abort_after > 0) ? EV_ABORT : EV_DONE, e + 2 * k, 32'd0, exp_checksum(sum));
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = n;
        abort    = abort_with_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        if (abort_after > 0) begin
            while (cyc < e + 2 * abort_after - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        int e;
        for (int i = 0; i < 256; i++) shadow[i] = 32'd0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        src_addr  = 32'd0;
        dst_addr  = 32'd0;
        len       = 16'd0;
        poke_en   = 1'b0;
        poke_addr = 8'd0;
        poke_data = 32'd0;
        for (int i = 0; i < 256; i++) poke(8'(i), 32'd0);

        // Reset state
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset aborted", 64'(aborted), 64'd0);
        check("reset mem_read", 64'(mem_read), 64'd0);
        check("reset mem_write", 64'(mem_write), 64'd0);
        check("reset mem_addr", 64'(mem_addr), 64'd0);
        check("reset mem_wdata", 64'(mem_wdata), 64'd0);
        check("reset checksum", 64'(checksum), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Basic 4-word copy: done in cycle 9, checksum 10 with the feature.
        poke(8'd10, 32'd1);
        poke(8'd11, 32'd2);
        poke(8'd12, 32'd3);
        poke(8'd13, 32'd4);
        run_copy(32'd10, 32'd100, 16'd4, 0, 1'b0);
        wait_drain(40);
        idle(3);
        for (int i = 0; i < 4; i++) check("copy dst word", 64'(mem[100 + i]), 64'(i + 1));
        check("checksum held after done", 64'(checksum), 64'(exp_checksum(32'd10)));

        // Zero-length request: done in cycle 1, no memory traffic.
        run_copy(32'd10, 32'd110, 16'd0, 0, 1'b0);
        wait_drain(20);
        idle(3);

        // Overlapping forward copy propagates the first word.
        poke(8'd20, 32'd7);
        poke(8'd21, 32'd8);
        poke(8'd22, 32'd9);
        poke(8'd23, 32'd5);
        run_copy(32'd20, 32'd21, 16'd3, 0, 1'b0);
        wait_drain(40);
        idle(2);
        for (int i = 21; i < 24; i++) check("overlap word", 64'(mem[i]), 64'd7);

        // Abort during the 3rd WRITE: three words land, aborted pulse, no done.
        for (int i = 0; i < 8; i++) poke(8'(30 + i), 32'h30 + 32'(i));
        poke(8'd203, 32'hBAD);
        run_copy(32'd30, 32'd200, 16'd8, 3, 1'b0);
        wait_drain(40);
        idle(6);
        check("abort 3rd word written", 64'(mem[202]), 64'h32);
        check("abort 4th word untouched", 64'(mem[203]), 64'hBAD);
        check("abort returns idle", 64'(busy), 64'd0);

        // Address wrap: reads FFFFFFFF then 0.
        poke(8'd255, 32'hAA);
        poke(8'd0, 32'hBB);
        run_copy(32'hFFFF_FFFF, 32'd5, 16'd2, 0, 1'b0);
        wait_drain(40);
        idle(2);
        check("wrap word 0", 64'(mem[5]), 64'hAA);
        check("wrap word 1", 64'(mem[6]), 64'hBB);

        // Reset asserted mid-WRITE: outputs drop at once, no write committed.
        poke(8'd40, 32'h11);
        poke(8'd150, 32'hDEAD);
        @(negedge clk);
        e = cyc + 1;
        push(EV_READ, e, 32'd40, 32'd0);
        start    = 1'b1;
        src_addr = 32'd40;
        dst_addr = 32'd150;
        len      = 16'd2;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst mid-write mem_write", 64'(mem_write), 64'd0);
        check("rst mid-write mem_addr", 64'(mem_addr), 64'd0);
        check("rst mid-write mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst mid-write busy", 64'(busy), 64'd0);
        check("rst mid-write checksum", 64'(checksum), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_drain(5);
        idle(3);
        check("rst mid-write no commit", 64'(mem[150]), 64'hDEAD);

        // After reset: len=1 completes; abort alongside start loses to start.
        poke(8'd50, 32'h55);
        run_copy(32'd50, 32'd60, 16'd1, 0, 1'b1);
        wait_drain(20);
        idle(3);
        check("post-reset copy word", 64'(mem[60]), 64'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_copy_engine.md
Name: dm_copy_engine

Overview:
- Word-copy initiator that masters the data-memory port: reads a block of words from a source address and writes them to a destination address.
- Sits beside the datapath and connects to the data memory's MemRead/MemWrite/address/WriteData/ReadData port through the top-level mux while busy.
- The data memory has a combinational read and a clocked write, so each word takes one read cycle and one write cycle.

Parameters:
- ADDR_W, 32, width of word addresses (the data memory indexes whole words).
- DATA_W, 32, data word width.
- LEN_W, 16, width of the transfer length in words.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request pulse; accepted only in IDLE.
- src_addr  input  ADDR_W  first source word address; sampled on start accept.
- dst_addr  input  ADDR_W  first destination word address; sampled on start accept.
- len  input  LEN_W  number of words to copy; sampled on start accept.
- abort  input  1  stop the transfer at the next edge.
- busy  output  1  high in READ and WRITE.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse when a transfer is terminated by abort.
- mem_read  output  1  drives MemRead.
- mem_write  output  1  drives MemWrite.
- mem_addr  output  ADDR_W  drives the memory address.
- mem_wdata  output  DATA_W  drives WriteData.
- mem_rdata  input  DATA_W  ReadData from memory (combinational in address).
- checksum  output  DATA_W  running sum of copied words (see Optional Feature).

Behaviour:
- States: IDLE, READ, WRITE, FIN.
- Reset, asynchronous, any state:
  - state goes to IDLE.
  - Internal registers clear: src, dst, remaining count, data buffer, checksum.
  - busy, done, aborted, mem_read and mem_write are 0; mem_addr and mem_wdata are 0.
  - Reset in WRITE produces no write: mem_write falls with rst.
- IDLE:
  - All memory outputs are 0.
  - start=1 latches src_addr, dst_addr and len, and clears checksum.
  - If len==0, go to FIN; otherwise go to READ.
  - start outside IDLE is ignored.
- READ:
  - mem_read=1, mem_addr=src.
  - On the edge, mem_rdata is captured into the buffer and the state goes to WRITE.
- WRITE:
  - mem_write=1, mem_addr=dst, mem_wdata=buffer.
  - On the edge: src+1, dst+1, remaining-1.
  - If remaining was 1, go to FIN; otherwise go to READ.
- FIN: done=1 for exactly one cycle, then IDLE.
- Output timing:
  - Memory-side outputs are decoded combinationally from state and registers; they are glitch-free relative to clk.
  - mem_read and mem_write are never high in the same cycle.
- Latency: with start accepted at edge 0, done is high in cycle 2*len+1 (length-0 request: cycle 1). Throughput is 2 cycles per word.
- Address arithmetic: modulo 2^ADDR_W; wrap from all-ones to 0 is silent.
- Overlap: copy runs in strictly ascending address order.
  - dst within (src, src+len) propagates data forward. This is defined behaviour, not an error.
  - dst==src rewrites identical data.
- Abort:
  - abort=1 in READ or WRITE goes to IDLE at the next edge and pulses aborted for one cycle. No done.
  - The WRITE cycle in which abort is sampled still performs its write, since mem_write is already high.
  - abort in IDLE or FIN is ignored; FIN completes normally.
  - abort and start together in IDLE: start wins.
- Status: busy falls in FIN. A new start is accepted the cycle after FIN (IDLE).

Optional Feature:
- Macro: DM_COPY_CHECKSUM_EN.
- Defined:
  - checksum accumulates buffer values on every WRITE edge, modulo 2^DATA_W.
  - It is cleared on start accept and held after done or aborted until the next start.
- Undefined: checksum is tied to 0 and no accumulator register exists.

Test Plan:
- Preload mem[10..13]=1,2,3,4; start src=10 dst=100 len=4 -> mem[100..103]=1,2,3,4; done high exactly in cycle 9; busy high cycles 1-8; checksum=10 with the macro, 0 without.
- start len=0 -> no mem_read/mem_write; done pulses in cycle 1.
- Overlap: mem[20..22]=7,8,9; src=20 dst=21 len=3 -> mem[21..23]=7,7,7.
- Abort: len=8, assert abort during the 3rd WRITE -> 3 words written, aborted pulses one cycle, done never asserts, state IDLE.
- Wrap: src=32'hFFFFFFFF, dst=5, len=2 with a wrapping memory model -> reads addresses FFFFFFFF then 0.
- rst asserted mid-WRITE -> outputs 0 immediately, no write committed that cycle; a subsequent start with len=1 completes normally.
